lsu_multicycle: RTL and testbench

Multi-cycle load/store unit that replaces the single-cycle, combinational memory access path between execute and write-back. It accepts one memory operation at a time over a valid/ready handshake, issues a word-aligned request to a variable-latency memory port, and aligns and extends sub-word data. It returns the result to write-back over a second handshake. It also detects misaligned accesses, bus errors and response timeouts.

---
 rtl/lsu_pkg.sv | 44 ++++
 rtl/lsu_if.sv | 25 ++
 rtl/lsu_lane_align.sv | 40 ++++
 rtl/lsu_multicycle.sv | 127 ++++++++++++
 tb/tb_lsu_multicycle.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants, state enum and decode helpers for the multi-cycle LSU.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_BUS      = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } lsu_state_t;

  // Unknown encodings (3, 6, 7) fall through to word width.
  function automatic logic [1:0] access_size(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      F3_W:        return SZ_W;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (access_size(funct3))
      SZ_B:    return 1'b0;
      SZ_H:    return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - word-aligned memory request/response port between the LSU and memory.
interface lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) ();
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic                mem_req_we;
  logic [ADDR_W-1:0]   mem_req_addr;
  logic [XLEN-1:0]     mem_req_wdata;
  logic [XLEN/8-1:0]   mem_req_wmask;
  logic                mem_resp_valid;
  logic [XLEN-1:0]     mem_resp_rdata;
  logic                mem_resp_err;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
  );
endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane placement for stores and lane extract/extend for loads.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wmask,
  output logic [31:0] ld_data
);

  logic [1:0]  size;
  logic [15:0] shifted;

  assign size    = access_size(funct3);
  assign shifted = 16'(rdata >> {addr_lo, 3'b000});

  // funct3[2] marks the unsigned load variants.
  always_comb begin
    st_wdata = wdata;
    st_wmask = 4'hF;
    ld_data  = rdata;
    case (size)
      SZ_B: begin
        st_wdata = {4{wdata[7:0]}};
        st_wmask = 4'b0001 << addr_lo;
        ld_data  = funct3[2] ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        st_wdata = {2{wdata[15:0]}};
        st_wmask = 4'b0011 << addr_lo;
        ld_data  = funct3[2] ? {16'b0, shifted} : {{16{shifted[15]}}, shifted};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_multicycle.sv
// rtl/lsu_multicycle.sv - one-op-at-a-time load/store unit with variable-latency memory port.
module lsu_multicycle
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  lsu_if.master             mem,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rdata,
  output logic [1:0]        out_err,
  output logic              busy
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  lsu_state_t        state, state_nxt;
  logic              op_load, op_store;
  logic [2:0]        op_funct3;
  logic [ADDR_W-1:0] op_addr;
  logic [XLEN-1:0]   op_wdata;
  logic [CNT_W-1:0]  cnt;
  logic              drain;
  logic [31:0]       st_wdata, ld_data;
  logic [3:0]        st_wmask;
  logic              mem_op, misalign, resp_take, timeout_hit;

  assign mem_op      = in_is_load | in_is_store;
  assign misalign    = is_misaligned(in_funct3, in_addr[1:0]);
  // A response owed to a timed-out request must never complete a later op.
  assign resp_take   = mem.mem_resp_valid && !drain;
  assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_VAL);

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);

  assign mem.mem_req_valid = (state == S_REQ);
  assign mem.mem_req_we    = op_store;
  assign mem.mem_req_addr  = {op_addr[ADDR_W-1:2], 2'b00};
  assign mem.mem_req_wdata = st_wdata;
  assign mem.mem_req_wmask = op_store ? st_wmask : 4'h0;

  lsu_lane_align u_align (
    .funct3   (op_funct3),
    .addr_lo  (op_addr[1:0]),
    .wdata    (op_wdata),
    .rdata    (mem.mem_resp_rdata),
    .st_wdata (st_wdata),
    .st_wmask (st_wmask),
    .ld_data  (ld_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid) state_nxt = (!mem_op || misalign) ? S_DONE : S_REQ;
      S_REQ:  if (mem.mem_req_ready) state_nxt = S_WAIT;
      S_WAIT: if (resp_take || timeout_hit) state_nxt = S_DONE;
      S_DONE: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_load   <= 1'b0;
      op_store  <= 1'b0;
      op_funct3 <= 3'd0;
      op_addr   <= '0;
      op_wdata  <= '0;
      cnt       <= '0;
      drain     <= 1'b0;
      out_rdata <= '0;
      out_err   <= ERR_NONE;
    end else begin
      if (drain && mem.mem_resp_valid) drain <= 1'b0;
      case (state)
        S_IDLE: if (in_valid) begin
          op_load   <= in_is_load;
          op_store  <= in_is_store & ~in_is_load;
          op_funct3 <= in_funct3;
          op_addr   <= in_addr;
          op_wdata  <= in_wdata;
          out_rdata <= '0;
          out_err   <= (mem_op && misalign) ? ERR_MISALIGN : ERR_NONE;
        end
        S_REQ: if (mem.mem_req_ready) cnt <= '0;
        S_WAIT: begin
          if (resp_take) begin
            out_err   <= mem.mem_resp_err ? ERR_BUS : ERR_NONE;
            out_rdata <= (mem.mem_resp_err || !op_load) ? '0 : ld_data;
          end else if (timeout_hit) begin
            out_err   <= ERR_TIMEOUT;
            out_rdata <= '0;
            drain     <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: if (out_ready) begin
          out_rdata <= '0;
          out_err   <= ERR_NONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_multicycle.sv
// tb/tb_lsu_multicycle.sv - directed self-checking bench for lsu_multicycle (TIMEOUT = 4).
module tb_lsu_multicycle;

  logic        clk, rst;
  logic        in_valid, in_ready, in_is_load, in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic        out_valid, out_ready, busy;
  logic [31:0] out_rdata;
  logic [1:0]  out_err;
  int          tests, fails;

  lsu_if #(.XLEN(32), .ADDR_W(32)) mem_bus ();

  lsu_multicycle #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_is_load  (in_is_load),
    .in_is_store (in_is_store),
    .in_funct3   (in_funct3),
    .in_addr     (in_addr),
    .in_wdata    (in_wdata),
    .mem         (mem_bus),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rdata   (out_rdata),
    .out_err     (out_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
    in_valid = 1'b1; in_is_load = ld; in_is_store = st;
    in_funct3 = f3; in_addr = addr; in_wdata = wd;
    @(negedge clk);
    in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
  endtask

  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp);
    mem_bus.mem_req_ready = 1'b1; out_ready = 1'b1;
    drive_op(1'b1, 1'b0, f3, addr, 32'h0);
    check({tag, "_req_valid"}, 32'(mem_bus.mem_req_valid), 32'd1);
    check({tag, "_req_addr"},  mem_bus.mem_req_addr, addr & 32'hFFFF_FFFC);
    check({tag, "_req_wmask"}, 32'(mem_bus.mem_req_wmask), 32'h0);
    @(negedge clk);
    check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
    mem_bus.mem_resp_valid = 1'b1; mem_bus.mem_resp_rdata = rdata; mem_bus.mem_resp_err = 1'b0;
    @(negedge clk);
    mem_bus.mem_resp_valid = 1'b0;
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_rdata"}, out_rdata, exp);
    check({tag, "_err"}, 32'(out_err), 32'd0);
    @(negedge clk);
    check({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] exp_mask,
                           input logic [31:0] exp_wdata);
    mem_bus.mem_req_ready = 1'b1; out_ready = 1'b1;
    drive_op(1'b0, 1'b1, f3, addr, wd);
    check({tag, "_we"},    32'(mem_bus.mem_req_we), 32'd1);
    check({tag, "_wmask"}, 32'(mem_bus.mem_req_wmask), 32'(exp_mask));
    check({tag, "_wdata"}, mem_bus.mem_req_wdata, exp_wdata);
    @(negedge clk);
    mem_bus.mem_resp_valid = 1'b1; mem_bus.mem_resp_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_bus.mem_resp_valid = 1'b0;
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_rdata"}, out_rdata, 32'h0);
    @(negedge clk);
  endtask

  task automatic run_misalign(input string tag, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr);
    out_ready = 1'b1;
    drive_op(~st, st, f3, addr, 32'h1234_5678);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_err"}, 32'(out_err), 32'd1);
    check({tag, "_req_valid"}, 32'(mem_bus.mem_req_valid), 32'd0);
    @(negedge clk);
    check({tag, "_req_valid2"}, 32'(mem_bus.mem_req_valid), 32'd0);
    check({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int bad;
    tests = 0; fails = 0;
    rst = 1'b0; in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
    in_funct3 = 3'd0; in_addr = 32'h0; in_wdata = 32'h0; out_ready = 1'b1;
    mem_bus.mem_req_ready = 1'b1; mem_bus.mem_resp_valid = 1'b0;
    mem_bus.mem_resp_rdata = 32'h0; mem_bus.mem_resp_err = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_req_valid", 32'(mem_bus.mem_req_valid), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_out_rdata", out_rdata, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // LB, sign extension of top lane; latency T+1 req, T+3 out
    run_load("lb3", 3'd0, 32'h8000_0003, 32'h80FF_1234, 32'hFFFF_FF80);
    run_load("lh2", 3'd1, 32'h8000_0002, 32'h8765_4321, 32'hFFFF_8765);
    run_load("lbu1", 3'd4, 32'h8000_0001, 32'h1234_5678, 32'h0000_0056);
    run_load("lb0", 3'd0, 32'h8000_0000, 32'hFFFF_FF7F, 32'h0000_007F);
    run_load("lw", 3'd2, 32'h8000_0008, 32'hCAFE_BABE, 32'hCAFE_BABE);
    run_load("f3_7", 3'd7, 32'h8000_000C, 32'h0BAD_F00D, 32'h0BAD_F00D);

    // SH with request backpressure
    mem_bus.mem_req_ready = 1'b0; out_ready = 1'b1;
    drive_op(1'b0, 1'b1, 3'd1, 32'h8000_0002, 32'h0000_ABCD);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_bus.mem_req_valid !== 1'b1 || mem_bus.mem_req_wmask !== 4'b1100 ||
          mem_bus.mem_req_wdata !== 32'hABCD_ABCD || mem_bus.mem_req_addr !== 32'h8000_0000)
        bad++;
      if (i == 3) mem_bus.mem_req_ready = 1'b1;
      else @(negedge clk);
    end
    check("sh_req_stable", 32'(bad), 32'd0);
    check("sh_wmask", 32'(mem_bus.mem_req_wmask), 32'hC);
    check("sh_wdata", mem_bus.mem_req_wdata, 32'hABCD_ABCD);
    check("sh_addr", mem_bus.mem_req_addr, 32'h8000_0000);
    @(negedge clk);
    check("sh_wait", 32'(mem_bus.mem_req_valid), 32'd0);
    mem_bus.mem_resp_valid = 1'b1;
    @(negedge clk);
    mem_bus.mem_resp_valid = 1'b0;
    check("sh_out_valid", 32'(out_valid), 32'd1);
    check("sh_rdata", out_rdata, 32'h0);
    @(negedge clk);

    run_store("sb1", 3'd0, 32'h8000_0001, 32'h1234_56A5, 4'b0010, 32'hA5A5_A5A5);
    run_store("sw", 3'd2, 32'h8000_0004, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

    run_misalign("lw_mis", 1'b0, 3'd2, 32'h8000_0001);
    run_misalign("sh_mis", 1'b1, 3'd1, 32'h8000_0003);

    // pass-through
    drive_op(1'b0, 1'b0, 3'd2, 32'h8000_0001, 32'hFFFF_FFFF);
    check("pt_out_valid", 32'(out_valid), 32'd1);
    check("pt_err", 32'(out_err), 32'd0);
    check("pt_rdata", out_rdata, 32'h0);
    check("pt_req_valid", 32'(mem_bus.mem_req_valid), 32'd0);
    @(negedge clk);

    // timeout: err 3 five cycles after entering WAIT
    drive_op(1'b1, 1'b0, 3'd2, 32'h8000_0010, 32'h0);
    check("to_req_valid", 32'(mem_bus.mem_req_valid), 32'd1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    check("to_early", 32'(bad), 32'd0);
    @(negedge clk);
    check("to_out_valid", 32'(out_valid), 32'd1);
    check("to_err", 32'(out_err), 32'd3);
    check("to_rdata", out_rdata, 32'h0);
    @(negedge clk);
    // stale response lands in the next load's WAIT and must be dropped
    drive_op(1'b1, 1'b0, 3'd2, 32'h8000_0020, 32'h0);
    @(negedge clk);
    mem_bus.mem_resp_valid = 1'b1; mem_bus.mem_resp_rdata = 32'h1111_1111;
    @(negedge clk);
    check("drain_no_done", 32'(out_valid), 32'd0);
    mem_bus.mem_resp_rdata = 32'h2222_3333;
    @(negedge clk);
    mem_bus.mem_resp_valid = 1'b0;
    check("drain_out_valid", 32'(out_valid), 32'd1);
    check("drain_rdata", out_rdata, 32'h2222_3333);
    check("drain_err", 32'(out_err), 32'd0);
    @(negedge clk);

    // bus error with WBU backpressure
    out_ready = 1'b0;
    drive_op(1'b1, 1'b0, 3'd5, 32'h8000_0002, 32'h0);
    @(negedge clk);
    mem_bus.mem_resp_valid = 1'b1; mem_bus.mem_resp_err = 1'b1; mem_bus.mem_resp_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_bus.mem_resp_valid = 1'b0; mem_bus.mem_resp_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("berr_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("berr_err%0d", i), 32'(out_err), 32'd2);
      check($sformatf("berr_rdata%0d", i), out_rdata, 32'h0);
      if (i == 2) out_ready = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    check("berr_released", 32'(out_valid), 32'd0);

    // reset in WAIT, then a response that must be ignored
    drive_op(1'b1, 1'b0, 3'd2, 32'h8000_0004, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("wrst_busy", 32'(busy), 32'd0);
    check("wrst_req_valid", 32'(mem_bus.mem_req_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    mem_bus.mem_resp_valid = 1'b1; mem_bus.mem_resp_rdata = 32'h5555_5555;
    @(negedge clk);
    mem_bus.mem_resp_valid = 1'b0;
    check("wrst_out_valid", 32'(out_valid), 32'd0);
    check("wrst_busy2", 32'(busy), 32'd0);
    check("wrst_in_ready", 32'(in_ready), 32'd1);
    run_load("post_rst", 3'd5, 32'h8000_0002, 32'h8765_4321, 32'h0000_8765);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
